// File: rtl/mem_fifo_pkg.sv
// mem_fifo_pkg: shared sizes, types and helpers for the FIFO-mode memory responder.
//   DATA_W    word width
//   CAPACITY  physical storage entries (power of 2)
//   ADDR_W    log2(CAPACITY); pointer width
//   CNT_W     occupancy width (ADDR_W+1, holds 0..CAPACITY)
//   DEPTH_W   width of the configured-depth input
//   ALMOST_W  width of the almost-threshold input
package mem_fifo_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned CAPACITY = 64;
    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned CNT_W    = ADDR_W + 1;
    localparam int unsigned DEPTH_W  = 16;
    localparam int unsigned ALMOST_W = 4;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Configured depth clamped into 1..CAPACITY; 0 and oversize values mean "use all entries".
    function automatic cnt_t eff_depth_f(input logic [DEPTH_W-1:0] depth);
        if ((depth == '0) || (depth > DEPTH_W'(CAPACITY))) begin
            return CNT_W'(CAPACITY);
        end
        return depth[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/mem_fifo_responder_if.sv
// mem_fifo_responder_if: wen_in/ren_in/valid_out stream bus between an initiator and the responder.
//   data_in, wen_in, ren_in              initiator -> responder (write data, write/read request)
//   data_out, valid_out                  responder -> initiator (registered read data and its valid)
//   full, empty, almost_full,
//   almost_empty, num_words              responder -> initiator (occupancy status)
// master = initiator side, slave = responder side.
interface mem_fifo_responder_if;
    import mem_fifo_pkg::*;

    word_t data_in;
    logic  wen_in;
    logic  ren_in;
    word_t data_out;
    logic  valid_out;
    logic  full;
    logic  empty;
    logic  almost_full;
    logic  almost_empty;
    cnt_t  num_words;

    modport master (
        output data_in, wen_in, ren_in,
        input  data_out, valid_out, full, empty, almost_full, almost_empty, num_words
    );

    modport slave (
        input  data_in, wen_in, ren_in,
        output data_out, valid_out, full, empty, almost_full, almost_empty, num_words
    );

endinterface

// File: rtl/mem_fifo_sram.sv
// mem_fifo_sram: 1W1R synchronous SRAM model with a registered read port.
//   clk, reset     clock, async active-high reset (clears the read register only)
//   we/waddr/wdata write port, written on the rising edge when we=1
//   re/raddr       read request; rdata shows mem[raddr] the cycle after re and holds otherwise
//   rdata          registered read data
module mem_fifo_sram
    import mem_fifo_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  we,
    input  ptr_t  waddr,
    input  word_t wdata,
    input  logic  re,
    input  ptr_t  raddr,
    output word_t rdata
);

    word_t mem [CAPACITY];

    // Storage array: intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register: a same-address write in the same cycle returns the old word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mem_fifo_responder.sv
// mem_fifo_responder: FIFO-mode storage end of the wen_in/ren_in/valid_out stream protocol.
// Accepts words from an initiator and returns them in order with one-cycle read latency.
//   clk, reset     clock, async active-high reset
//   clk_en         0 freezes all state; no accepts; outputs hold
//   flush          synchronous clear of pointers, count and valid_out (needs clk_en)
//   depth          configured capacity; 0 or >CAPACITY selects CAPACITY; static while running
//   almost_count   almost_full / almost_empty threshold
//   bus            slave side of mem_fifo_responder_if (data, requests, read data, status)
module mem_fifo_responder
    import mem_fifo_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic                flush,
    input  logic [DEPTH_W-1:0]  depth,
    input  logic [ALMOST_W-1:0] almost_count,
    mem_fifo_responder_if.slave bus
);

    cnt_t  eff_depth;
    cnt_t  almost_ext;
    cnt_t  af_thresh;
    cnt_t  count;
    ptr_t  wr_ptr;
    ptr_t  rd_ptr;
    ptr_t  last_ptr;
    logic  is_full;
    logic  is_empty;
    logic  push;
    logic  pop;
    logic  valid_q;
    word_t rdata;

    // Effective depth and wrap point for both pointers.
    assign eff_depth  = eff_depth_f(depth);
    assign last_ptr   = ADDR_W'(eff_depth - CNT_W'(1));
    assign almost_ext = CNT_W'(almost_count);

    // Occupancy regions EMPTY / PARTIAL / FULL are read straight off count.
    assign is_full  = (count == eff_depth);
    assign is_empty = (count == '0);

    // almost_full threshold saturates at 0 when almost_count >= eff_depth.
    assign af_thresh = (eff_depth > almost_ext) ? (eff_depth - almost_ext) : '0;

    // Empty blocks pop even with a same-cycle push (no write-through);
    // a full FIFO still accepts a push when a pop frees the slot that cycle.
    // flush overrides both.
    assign pop  = clk_en & ~flush & bus.ren_in & ~is_empty;
    assign push = clk_en & ~flush & bus.wen_in & (~is_full | pop);

    function automatic ptr_t next_ptr(input ptr_t p, input ptr_t last);
        return (p == last) ? '0 : (p + ADDR_W'(1));
    endfunction

    // Pointers, occupancy and read-valid pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= pop;
                if (push) begin
                    wr_ptr <= next_ptr(wr_ptr, last_ptr);
                end
                if (pop) begin
                    rd_ptr <= next_ptr(rd_ptr, last_ptr);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    mem_fifo_sram u_sram (
        .clk   (clk),
        .reset (reset),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .re    (pop),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign bus.data_out     = rdata;
    assign bus.valid_out    = valid_q;
    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.almost_full  = (count >= af_thresh);
    assign bus.almost_empty = (count <= almost_ext);
    assign bus.num_words    = count;

endmodule
